// File: rtl/key_expand_if.sv
// key_expand_if: key-offer and round-key stream signals of the AES key
// schedule engine. The slave modport is the engine's view. The master
// modport is the key source / round datapath view.
interface key_expand_if #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4
);
  // key offer
  logic                 i_valid;
  logic [WORD*NK-1:0]   i_key;
  logic                 o_ready;
  // round-key stream
  logic                 o_valid;
  logic [WORD*NB-1:0]   o_roundkey;
  logic [3:0]           o_round;
  logic                 o_last;
  logic                 i_ready;

  modport master (
    output i_valid, i_key, i_ready,
    input  o_ready, o_valid, o_roundkey, o_round, o_last
  );

  modport slave (
    input  i_valid, i_key, i_ready,
    output o_ready, o_valid, o_roundkey, o_round, o_last
  );
endinterface

// File: rtl/key_expand.sv
// key_expand: AES key-schedule engine. It takes an NK-word cipher key
// (NK = 4, 6 or 8) and produces one 32-bit schedule word per cycle. Each
// group of four words is handed out as one round key, rounds 0..NR, through
// a valid/ready output register.
//
// Optional build macro KEYEXP_REVERSE_EN adds the i_reverse port. With
// i_reverse=1, all round keys are first stored in an on-chip array and are
// then streamed from round NR down to round 0 for the decryption datapath.
module key_expand #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef KEYEXP_REVERSE_EN
  input  logic i_reverse,
`endif
  key_expand_if.slave kif
);

  localparam int         NR         = NK + 6;
  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [5:0] NK_W       = 6'(NK);
  localparam logic [2:0] POS_WRAP   = 3'(NK - 1);

  // Forward AES S-box. Entry 0x00 is in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit offset (255-b)*8, which equals {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Next round constant: multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DRAIN} state_t;

  state_t              state_reg;
  // Sliding window: win_reg[0] is w[i-NK] and win_reg[NK-1] is w[i-1].
  logic [WORD-1:0]     win_reg [NK];
  // Assembly register: asm_reg[0] holds the oldest word of the round key.
  logic [WORD-1:0]     asm_reg [NB-1];
  logic [1:0]          asm_cnt_reg;
  logic [5:0]          i_reg;
  logic [2:0]          pos_reg;        // i mod NK
  logic [7:0]          rcon_reg;
  logic [3:0]          round_cnt_reg;  // round currently being assembled

  logic                o_ready_reg;
  logic                o_valid_reg;
  logic                o_last_reg;
  logic [WORD*NB-1:0]  o_roundkey_reg;
  logic [3:0]          o_round_reg;

  logic                rev_reg;

  logic                accept;
  logic                hs;
  logic                key_phase;
  logic                out_free;
  logic                gen_en;
  logic                xfer;
  logic [WORD-1:0]     prev_word;
  logic [WORD-1:0]     old_word;
  logic [WORD-1:0]     sub_prev;
  logic [WORD-1:0]     word_next;
  logic [WORD*NB-1:0]  full_key;

  assign accept    = (state_reg == S_IDLE) && o_ready_reg && kif.i_valid;
  assign hs        = o_valid_reg && kif.i_ready;
  assign key_phase = (i_reg < NK_W);
  assign prev_word = win_reg[NK-1];
  assign old_word  = win_reg[0];

  // In reverse mode, keys go to storage, so the output register never blocks.
  assign out_free = rev_reg ? 1'b1 : (!o_valid_reg || kif.i_ready);
  assign gen_en   = (state_reg == S_EXPAND) && ((asm_cnt_reg != 2'd3) || out_free);
  assign xfer     = gen_en && (asm_cnt_reg == 2'd3);
  assign full_key = {asm_reg[0], asm_reg[1], asm_reg[2], word_next};

  // SubWord of w[i-1]. SubWord(RotWord(x)) is the rotation of SubWord(x).
  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    assign sub_prev[8*gi +: 8] = sbox(prev_word[8*gi +: 8]);
  end

  // Schedule word w[i]. In the key phase, the window rotates, so win_reg[0]
  // is key word i.
  always_comb begin
    word_next = old_word ^ prev_word;
    if (key_phase) begin
      word_next = old_word;
    end else if (pos_reg == 3'd0) begin
      word_next = old_word ^ {sub_prev[23:0], sub_prev[31:24]} ^ {rcon_reg, 24'h000000};
    end else if ((NK == 8) && (pos_reg == 3'd4)) begin
      word_next = old_word ^ sub_prev;
    end
  end

`ifdef KEYEXP_REVERSE_EN
  localparam int RKEYS = NR + 1;

  logic [WORD*NB-1:0] rk_mem [RKEYS];
  logic [3:0]         rd_idx_reg;
  logic               rd_pend_reg;

  // Direction is latched together with the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      rev_reg <= 1'b0;
    end else if (accept) begin
      rev_reg <= i_reverse;
    end
  end

  // Round-key storage used for the reverse stream.
  always_ff @(posedge clk) begin
    if (xfer && rev_reg) begin
      rk_mem[round_cnt_reg] <= full_key;
    end
  end
`else
  assign rev_reg = 1'b0;
`endif

  // Control FSM, schedule datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      for (int k = 0; k < NK; k++) win_reg[k] <= '0;
      for (int k = 0; k < NB - 1; k++) asm_reg[k] <= '0;
      asm_cnt_reg    <= '0;
      i_reg          <= '0;
      pos_reg        <= '0;
      rcon_reg       <= 8'h01;
      round_cnt_reg  <= '0;
      o_ready_reg    <= 1'b0;
      o_valid_reg    <= 1'b0;
      o_last_reg     <= 1'b0;
      o_roundkey_reg <= '0;
      o_round_reg    <= '0;
`ifdef KEYEXP_REVERSE_EN
      rd_idx_reg     <= '0;
      rd_pend_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          o_ready_reg <= 1'b1;
          if (accept) begin
            o_ready_reg <= 1'b0;
            for (int k = 0; k < NK; k++) begin
              win_reg[k] <= kif.i_key[WORD*(NK-k)-1 -: WORD];
            end
            asm_cnt_reg   <= '0;
            i_reg         <= '0;
            pos_reg       <= '0;
            rcon_reg      <= 8'h01;
            round_cnt_reg <= '0;
            state_reg     <= S_EXPAND;
          end
        end

        S_EXPAND: begin
          if (hs) begin
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
          end
          if (gen_en) begin
            for (int k = 0; k < NK - 1; k++) win_reg[k] <= win_reg[k+1];
            win_reg[NK-1] <= word_next;
            i_reg   <= i_reg + 6'd1;
            pos_reg <= (pos_reg == POS_WRAP) ? 3'd0 : pos_reg + 3'd1;
            if (!key_phase && (pos_reg == 3'd0)) begin
              rcon_reg <= xtime(rcon_reg);
            end
            if (asm_cnt_reg != 2'd3) begin
              asm_reg[0]  <= asm_reg[1];
              asm_reg[1]  <= asm_reg[2];
              asm_reg[2]  <= word_next;
              asm_cnt_reg <= asm_cnt_reg + 2'd1;
            end else begin
              asm_cnt_reg   <= '0;
              round_cnt_reg <= round_cnt_reg + 4'd1;
              if (!rev_reg) begin
                o_valid_reg    <= 1'b1;
                o_roundkey_reg <= full_key;
                o_round_reg    <= round_cnt_reg;
                o_last_reg     <= (round_cnt_reg == LAST_ROUND);
              end
              if (round_cnt_reg == LAST_ROUND) begin
                state_reg <= S_DRAIN;
`ifdef KEYEXP_REVERSE_EN
                rd_idx_reg  <= LAST_ROUND;
                rd_pend_reg <= 1'b1;
`endif
              end
            end
          end
        end

        S_DRAIN: begin
`ifdef KEYEXP_REVERSE_EN
          if (rev_reg) begin
            if (hs && o_last_reg) begin
              state_reg   <= S_IDLE;
              o_valid_reg <= 1'b0;
              o_last_reg  <= 1'b0;
              o_ready_reg <= 1'b1;
            end else if (!o_valid_reg || kif.i_ready) begin
              if (rd_pend_reg) begin
                o_valid_reg    <= 1'b1;
                o_roundkey_reg <= rk_mem[rd_idx_reg];
                o_round_reg    <= rd_idx_reg;
                o_last_reg     <= (rd_idx_reg == 4'd0);
                if (rd_idx_reg == 4'd0) begin
                  rd_pend_reg <= 1'b0;
                end else begin
                  rd_idx_reg <= rd_idx_reg - 4'd1;
                end
              end else begin
                o_valid_reg <= 1'b0;
              end
            end
          end else if (hs) begin
`else
          if (hs) begin
`endif
            state_reg   <= S_IDLE;
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_ready_reg <= 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign kif.o_ready    = o_ready_reg;
  assign kif.o_valid    = o_valid_reg;
  assign kif.o_roundkey = o_roundkey_reg;
  assign kif.o_round    = o_round_reg;
  assign kif.o_last     = o_last_reg;

endmodule

// File: tb/tb_key_expand.sv
// tb_key_expand: directed-vector bench for key_expand (NK=4 and NK=8 instances).
module tb_key_expand;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_expand_if #(.WORD(32), .NB(4), .NK(4)) kif4 ();
  key_expand_if #(.WORD(32), .NB(4), .NK(8)) kif8 ();

`ifdef KEYEXP_REVERSE_EN
  logic rev4;
  logic rev8;
`endif

  key_expand #(.WORD(32), .NB(4), .NK(4)) u_dut4 (
    .clk(clk),
    .rst(rst),
`ifdef KEYEXP_REVERSE_EN
    .i_reverse(rev4),
`endif
    .kif(kif4)
  );

  key_expand #(.WORD(32), .NB(4), .NK(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
`ifdef KEYEXP_REVERSE_EN
    .i_reverse(rev8),
`endif
    .kif(kif8)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] key_a;
  logic [127:0] rk_a    [11];
  logic [127:0] exp_tab [11];
  int           exp_n;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a key to the NK=4 engine; the accepting edge is E0.
  task automatic offer4(input logic [127:0] key);
    int w;
    w = 0;
    while (!kif4.o_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("offer_ready", kif4.o_ready, 1);
    kif4.i_valid = 1'b1;
    kif4.i_key   = key;
    tick();
    kif4.i_valid = 1'b0;
    check_eq("accept_busy", kif4.o_ready, 0);
  endtask

  // Follow one NK=4 stream after E0. i_ready is sampled low at edges
  // low_from..low_to-1. Returns the edge index where round 10 is presented.
  task automatic run_stream(input int low_from, input int low_to, input bit busy,
                            output int fin_edge);
    int n;
    int er;
    bit done;
    n = 0;
    er = 0;
    done = 0;
    fin_edge = -1;
    kif4.i_ready = 1'b1;
    while (!done && n < 200) begin
      tick();
      n++;
      if (busy && n == 6) begin
        kif4.i_valid = 1'b1;
        kif4.i_key   = '0;
      end
      if (busy && n == 8) check_eq("busy_ready", kif4.o_ready, 0);
      kif4.i_ready = !((n + 1) >= low_from && (n + 1) < low_to);
      if (kif4.o_valid) begin
        if (er < exp_n) check_eq($sformatf("rk%0d", er), kif4.o_roundkey, exp_tab[er]);
        check_eq($sformatf("round%0d", er), kif4.o_round, er);
        check_eq($sformatf("last%0d", er), kif4.o_last, (er == 10));
        if (kif4.i_ready) begin
          if (er == 10) begin
            fin_edge = n;
            done = 1;
          end
          er++;
        end
      end
    end
    check_eq("stream_done", done, 1);
    tick();
    check_eq("post_valid", kif4.o_valid, 0);
    check_eq("post_ready", kif4.o_ready, 1);
  endtask

  initial begin : main
    int fin;
    int n;
    int er;

    key_a    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1;
    kif4.i_valid = 1'b0; kif4.i_key = '0; kif4.i_ready = 1'b0;
    kif8.i_valid = 1'b0; kif8.i_key = '0; kif8.i_ready = 1'b0;
`ifdef KEYEXP_REVERSE_EN
    rev4 = 1'b0;
    rev8 = 1'b0;
`endif
    tick();
    tick();
    check_eq("rst_ready", kif4.o_ready, 0);
    check_eq("rst_valid", kif4.o_valid, 0);
    check_eq("rst_key", kif4.o_roundkey, 0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", kif4.o_ready, 1);

    // Plain NK=4 stream.
    exp_tab = rk_a;
    exp_n = 11;
    offer4(key_a);
    run_stream(0, 0, 1'b0, fin);
    check_eq("fin_edge_plain", fin, 44);

    // Back-pressure on round 2: seven cycles with the assembly register full.
    offer4(key_a);
    run_stream(13, 23, 1'b0, fin);
    check_eq("fin_edge_stall", fin, 51);

    // Key offered mid-expansion: ignored until IDLE, then accepted.
    offer4(key_a);
    run_stream(0, 0, 1'b1, fin);
    check_eq("fin_edge_busy", fin, 44);
    tick();
    kif4.i_valid = 1'b0;
    check_eq("busy_accept", kif4.o_ready, 0);
    exp_tab[0] = 128'h00000000000000000000000000000000;
    exp_tab[1] = 128'h62636363626363636263636362636363;
    exp_tab[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    exp_n = 3;
    run_stream(0, 0, 1'b0, fin);
    check_eq("fin_edge_zero", fin, 44);

    // Reset at E20 in the middle of an expansion.
    exp_tab = rk_a;
    exp_n = 11;
    offer4(key_a);
    kif4.i_ready = 1'b1;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_ready", kif4.o_ready, 0);
    check_eq("mid_rst_valid", kif4.o_valid, 0);
    check_eq("mid_rst_last", kif4.o_last, 0);
    check_eq("mid_rst_key", kif4.o_roundkey, 0);
    check_eq("mid_rst_round", kif4.o_round, 0);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_ready_up", kif4.o_ready, 1);
    offer4(key_a);
    run_stream(0, 0, 1'b0, fin);
    check_eq("fin_edge_after_rst", fin, 44);

    // NK=8 stream.
    kif8.i_ready = 1'b1;
    kif8.i_valid = 1'b1;
    kif8.i_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    tick();
    kif8.i_valid = 1'b0;
    check_eq("nk8_accept", kif8.o_ready, 0);
    n = 0;
    er = 0;
    fin = -1;
    while (fin < 0 && n < 200) begin
      tick();
      n++;
      if (kif8.o_valid) begin
        check_eq($sformatf("nk8_round%0d", er), kif8.o_round, er);
        check_eq($sformatf("nk8_last%0d", er), kif8.o_last, (er == 14));
        case (er)
          0:  check_eq("nk8_rk0", kif8.o_roundkey, 128'h000102030405060708090a0b0c0d0e0f);
          1:  check_eq("nk8_rk1", kif8.o_roundkey, 128'h101112131415161718191a1b1c1d1e1f);
          2:  check_eq("nk8_rk2", kif8.o_roundkey, 128'ha573c29fa176c498a97fce93a572c09c);
          3:  check_eq("nk8_rk3", kif8.o_roundkey, 128'h1651a8cd0244beda1a5da4c10640bade);
          14: check_eq("nk8_rk14", kif8.o_roundkey, 128'h24fc79ccbf0979e9371ac23c6d68de36);
          default: ;
        endcase
        if (er == 14) fin = n;
        er++;
      end
    end
    check_eq("nk8_fin_edge", fin, 60);
    tick();
    check_eq("nk8_post_ready", kif8.o_ready, 1);

`ifdef KEYEXP_REVERSE_EN
    begin : rev_test
      int first;
      int lastn;
      int hs_cnt;
      rev4 = 1'b1;
      kif4.i_ready = 1'b1;
      offer4(key_a);
      rev4 = 1'b0;
      n = 0;
      er = 10;
      first = -1;
      lastn = -1;
      hs_cnt = 0;
      while (lastn < 0 && n < 200) begin
        tick();
        n++;
        if (kif4.o_valid) begin
          if (first < 0) first = n;
          check_eq($sformatf("rev_rk%0d", er), kif4.o_roundkey, rk_a[er]);
          check_eq($sformatf("rev_round%0d", er), kif4.o_round, er);
          check_eq($sformatf("rev_last%0d", er), kif4.o_last, (er == 0));
          hs_cnt++;
          if (er == 0) lastn = n;
          else er--;
        end
      end
      check_eq("rev_done", (lastn >= 0), 1);
      check_eq("rev_after_expand", (first > 43), 1);
      check_eq("rev_span", lastn - first, 10);
      check_eq("rev_count", hs_cnt, 11);
      tick();
      check_eq("rev_post_ready", kif4.o_ready, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
